// File: rtl/uba_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uba_pkg                                               |
// | Purpose  : Shared definitions for the UBA status controller:     |
// |            status-word bit positions, PI-level type and field    |
// |            extractors for backplane write data.                  |
// | Ports    : none (package)                                        |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package uba_pkg;

  // Bit numbers follow the backplane convention: bit 0 is the MSB.
  localparam int c_BIT_TMO = 18;
  localparam int c_BIT_NXD = 21;
  localparam int c_BIT_HI  = 24;
  localparam int c_BIT_LO  = 25;
  localparam int c_BIT_PWR = 26;
  localparam int c_BIT_DXF = 28;
  localparam int c_BIT_INI = 29;
  localparam int c_BIT_PIH = 30;
  localparam int c_BIT_PIL = 33;

  typedef logic [0:2]  pia_t;
  typedef logic [0:35] word_t;

  function automatic logic getTmo(input word_t d);
    return d[c_BIT_TMO];
  endfunction

  function automatic logic getNxd(input word_t d);
    return d[c_BIT_NXD];
  endfunction

  function automatic logic getDxf(input word_t d);
    return d[c_BIT_DXF];
  endfunction

  function automatic logic getIni(input word_t d);
    return d[c_BIT_INI];
  endfunction

  function automatic pia_t getPih(input word_t d);
    return d[c_BIT_PIH +: 3];
  endfunction

  function automatic pia_t getPil(input word_t d);
    return d[c_BIT_PIL +: 3];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uba_stat_ctl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uba_stat_ctl_if                                       |
// | Purpose  : Backplane access to the UBA status register.          |
// | Signals  : busDATAI  [0:35] write data (bus -> register)         |
// |            statWRITE        one-cycle write strobe               |
// |            regUBASR  [0:35] register read value                  |
// | Modports : master = bus decode side, slave = status controller   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
interface uba_stat_ctl_if;
  logic [0:35] busDATAI;
  logic        statWRITE;
  logic [0:35] regUBASR;

  modport master (output busDATAI, output statWRITE, input  regUBASR);
  modport slave  (input  busDATAI, input  statWRITE, output regUBASR);
endinterface
`default_nettype wire

// File: rtl/uba_oneshot.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uba_oneshot                                           |
// | Purpose  : Retriggerable timed one-shot. A trig loads the down-  |
// |            counter with CYCLES; busy is high while it is non-    |
// |            zero, i.e. for exactly CYCLES cycles after the trig.  |
// | Ports    : clk, rst (sync, active-high), trig in, busy out       |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module uba_oneshot #(
  parameter int CYCLES = 60
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic busy
);

  localparam int c_W = $clog2(CYCLES + 1);
  localparam logic [c_W-1:0] c_LOAD = c_W'(CYCLES);

  logic [c_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (trig) begin
      r_count <= c_LOAD;
    end else if (r_count != '0) begin
      r_count <= r_count - c_W'(1);
    end
  end

  assign busy = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/uba_stat_ctl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : uba_stat_ctl                                          |
// | Purpose  : UBA status register with timed INI one-shot and PI    |
// |            interrupt request generation for NUM_DEV devices.     |
// | Ports    : clk, rst       clock, sync active-high reset          |
// |            bus (slave)    busDATAI / statWRITE / regUBASR        |
// |            setTMO/setNXD  adapter timeout / non-existent device  |
// |            devACLO        per-device power-fail                  |
// |            devINTR        per-device BR7..BR4 requests           |
// |            ubaINIT        bridge device reset while INI runs     |
// |            ubaINTR[1:7]   PI request lines, bit n = level n      |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module uba_stat_ctl
  import uba_pkg::*;
#(
  parameter int NUM_DEV    = 4,
  parameter int INI_CYCLES = 60,
  parameter int ERR_INTR   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  uba_stat_ctl_if.slave            bus,
  input  logic                     setTMO,
  input  logic                     setNXD,
  input  logic [NUM_DEV-1:0]       devACLO,
  input  logic [NUM_DEV-1:0][7:4]  devINTR,
  output logic                     ubaINIT,
  output logic [1:7]               ubaINTR
);

  logic        r_tmo;
  logic        r_nxd;
  logic        r_dxf;
  pia_t        r_pih;
  pia_t        r_pil;
  logic [1:7]  r_intr;

  logic        w_hi;
  logic        w_lo;
  logic        w_pwr;
  logic        w_hiReq;
  logic        w_wrIni;
  logic        w_clrTmo;
  logic        w_clrNxd;
  logic        w_iniBusy;
  logic [1:7]  w_intr;
  word_t       w_reg;
  logic        w_unusedBits;

  // Reserved data bits are never decoded.
  assign w_unusedBits = &{bus.busDATAI[0:17], bus.busDATAI[19:20],
                          bus.busDATAI[22:27]};

  // Live request summary over the devices that exist.
  always_comb begin
    w_hi = 1'b0;
    w_lo = 1'b0;
    for (int d = 0; d < NUM_DEV; d++) begin
      w_hi = w_hi | devINTR[d][7] | devINTR[d][6];
      w_lo = w_lo | devINTR[d][5] | devINTR[d][4];
    end
    w_pwr = |devACLO;
  end

  // An INI write is a pure initialise: all other write data is dropped.
  assign w_wrIni  = bus.statWRITE & getIni(bus.busDATAI);
  assign w_clrTmo = bus.statWRITE & (w_wrIni | getTmo(bus.busDATAI));
  assign w_clrNxd = bus.statWRITE & (w_wrIni | getNxd(bus.busDATAI));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo  <= 1'b0;
      r_nxd  <= 1'b0;
      r_dxf  <= 1'b0;
      r_pih  <= '0;
      r_pil  <= '0;
      r_intr <= '0;
    end else begin
      // Set events take priority over a write-1-to-clear in the same cycle.
      if (setTMO || setNXD) r_tmo <= 1'b1;
      else if (w_clrTmo)    r_tmo <= 1'b0;

      if (setNXD)           r_nxd <= 1'b1;
      else if (w_clrNxd)    r_nxd <= 1'b0;

      if (w_wrIni) begin
        r_dxf <= 1'b0;
        r_pih <= '0;
        r_pil <= '0;
      end else if (bus.statWRITE) begin
        r_dxf <= getDxf(bus.busDATAI);
        r_pih <= getPih(bus.busDATAI);
        r_pil <= getPil(bus.busDATAI);
      end

      r_intr <= w_intr;
    end
  end

  // Level 0 means the channel is off; equal levels merge onto one line.
  always_comb begin
    w_intr  = '0;
    w_hiReq = w_hi | ((ERR_INTR != 0) & (r_tmo | r_nxd));
    if (r_pih != 3'd0) w_intr[r_pih] = w_hiReq;
    if (r_pil != 3'd0) w_intr[r_pil] = w_intr[r_pil] | w_lo;
  end

  uba_oneshot #(
    .CYCLES (INI_CYCLES)
  ) u_iniShot (
    .clk  (clk),
    .rst  (rst),
    .trig (w_wrIni),
    .busy (w_iniBusy)
  );

  assign ubaINIT = w_iniBusy;
  // Gate at the output so no request escapes during the first INI cycle.
  assign ubaINTR = w_iniBusy ? 7'd0 : r_intr;

  always_comb begin
    w_reg              = '0;
    w_reg[c_BIT_TMO]   = r_tmo;
    w_reg[c_BIT_NXD]   = r_nxd;
    w_reg[c_BIT_HI]    = w_hi;
    w_reg[c_BIT_LO]    = w_lo;
    w_reg[c_BIT_PWR]   = w_pwr;
    w_reg[c_BIT_DXF]   = r_dxf;
    w_reg[c_BIT_INI]   = w_iniBusy;
    w_reg[c_BIT_PIH +: 3] = r_pih;
    w_reg[c_BIT_PIL +: 3] = r_pil;
  end

  assign bus.regUBASR = w_reg;

endmodule
`default_nettype wire

// File: tb/tb_uba_stat_ctl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_uba_stat_ctl                                       |
// | Purpose  : Self-checking bench for uba_stat_ctl. Two instances   |
// |            (ERR_INTR = 0 and 1) share stimulus and are checked   |
// |            every cycle against a behavioural model, plus         |
// |            hand-computed literal expectations.                   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_uba_stat_ctl;

  localparam int ND  = 4;
  localparam int INI = 60;

  logic              clk = 1'b0;
  logic              rst;
  logic [0:35]       busDATAI;
  logic              statWRITE;
  logic              setTMO;
  logic              setNXD;
  logic [ND-1:0]     devACLO;
  logic [ND-1:0][7:4] devINTR;
  logic              init0, init1;
  logic [1:7]        intr0, intr1;

  int nCmp  = 0;
  int nFail = 0;
  bit started = 1'b0;

  uba_stat_ctl_if bus0 ();
  uba_stat_ctl_if bus1 ();
  assign bus0.busDATAI  = busDATAI;
  assign bus0.statWRITE = statWRITE;
  assign bus1.busDATAI  = busDATAI;
  assign bus1.statWRITE = statWRITE;

  uba_stat_ctl #(.NUM_DEV(ND), .INI_CYCLES(INI), .ERR_INTR(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .setTMO(setTMO), .setNXD(setNXD),
    .devACLO(devACLO), .devINTR(devINTR), .ubaINIT(init0), .ubaINTR(intr0));

  uba_stat_ctl #(.NUM_DEV(ND), .INI_CYCLES(INI), .ERR_INTR(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .setTMO(setTMO), .setNXD(setNXD),
    .devACLO(devACLO), .devINTR(devINTR), .ubaINIT(init1), .ubaINTR(intr1));

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          cyc = 0;
  int          iniUntil = 0;   // INI is active while cyc < iniUntil
  bit          mTmo, mNxd, mDxf;
  int          mPih, mPil;
  logic [1:7]  mIntr0, mIntr1; // registered requests before INI gating

  function automatic bit anyHi();
    bit r = 0;
    for (int d = 0; d < ND; d++) r = r || devINTR[d][7] || devINTR[d][6];
    return r;
  endfunction

  function automatic bit anyLo();
    bit r = 0;
    for (int d = 0; d < ND; d++) r = r || devINTR[d][5] || devINTR[d][4];
    return r;
  endfunction

  function automatic logic [1:7] reqLines(input bit err);
    logic [1:7] r = '0;
    bit hiReq = anyHi() || (err && (mTmo || mNxd));
    for (int lvl = 1; lvl <= 7; lvl++)
      r[lvl] = (mPih == lvl && hiReq) || (mPil == lvl && anyLo());
    return r;
  endfunction

  // Status word as a number: spec bit b carries weight 2**(35-b).
  function automatic logic [35:0] expReg();
    logic [35:0] v = '0;
    v = v | (36'(mTmo) << 17) | (36'(mNxd) << 14);
    v = v | (36'(anyHi()) << 11) | (36'(anyLo()) << 10) | (36'(|devACLO) << 9);
    v = v | (36'(mDxf) << 7) | (36'(cyc < iniUntil) << 6);
    v = v | (36'(mPih) << 3) | 36'(mPil);
    return v;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      mTmo = 0; mNxd = 0; mDxf = 0; mPih = 0; mPil = 0;
      iniUntil = 0; mIntr0 = '0; mIntr1 = '0;
    end else begin
      mIntr0 = reqLines(1'b0);
      mIntr1 = reqLines(1'b1);
      if (statWRITE && busDATAI[29]) begin
        mTmo = 0; mNxd = 0; mDxf = 0; mPih = 0; mPil = 0;
        iniUntil = cyc + INI;
      end else if (statWRITE) begin
        if (busDATAI[18]) mTmo = 0;
        if (busDATAI[21]) mNxd = 0;
        mDxf = busDATAI[28];
        mPih = int'(busDATAI[30:32]);
        mPil = int'(busDATAI[33:35]);
      end
      if (setTMO || setNXD) mTmo = 1;
      if (setNXD) mNxd = 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    nCmp = nCmp + 1;
    if (act !== exp) begin
      nFail = nFail + 1;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (started) begin
      bit iniOn;
      iniOn = (cyc < iniUntil);
      check("reg0",  64'(bus0.regUBASR), 64'(expReg()));
      check("reg1",  64'(bus1.regUBASR), 64'(expReg()));
      check("init0", 64'(init0), 64'(iniOn));
      check("init1", 64'(init1), 64'(iniOn));
      check("intr0", 64'(intr0), 64'(iniOn ? 7'd0 : mIntr0));
      check("intr1", 64'(intr1), 64'(iniOn ? 7'd0 : mIntr1));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [0:35] d);
    busDATAI  = d;
    statWRITE = 1'b1;
    tick();
    statWRITE = 1'b0;
    busDATAI  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1; busDATAI = '0; statWRITE = 1'b0; setTMO = 1'b0;
    setNXD = 1'b0; devACLO = '0; devINTR = '0;
    repeat (3) tick();
    rst = 1'b0;
    started = 1'b1;

    // Reset state
    @(negedge clk);
    check("lit_reset_reg", 64'(bus0.regUBASR), 64'(36'o0));
    check("lit_reset_intr", 64'(intr0), 64'(7'd0));

    // HI from device 2 BR6
    tick();
    devINTR[2][6] = 1'b1;
    @(negedge clk);
    check("lit_hi", 64'(bus0.regUBASR), 64'(36'o000000_004000));
    tick();
    devINTR = '0;
    devACLO[1] = 1'b1;
    @(negedge clk);
    check("lit_pwr", 64'(bus0.regUBASR), 64'(36'o000000_001000));
    tick();
    devACLO = '0;

    // NXD sets TMO as well; W1C on TMO only
    setNXD = 1'b1; tick(); setNXD = 1'b0;
    @(negedge clk);
    check("lit_nxd", 64'(bus0.regUBASR), 64'(36'o000000_440000));
    tick();
    wr(36'o000000_400000);
    @(negedge clk);
    check("lit_w1c_tmo", 64'(bus0.regUBASR), 64'(36'o000000_040000));
    tick();
    setTMO = 1'b1; busDATAI = 36'o000000_400000; statWRITE = 1'b1;
    tick();
    setTMO = 1'b0; busDATAI = '0; statWRITE = 1'b0;
    @(negedge clk);
    check("lit_set_wins", 64'(bus0.regUBASR), 64'(36'o000000_440000));
    tick();

    // DXF / PIH=5 / PIL=2 load
    wr(36'o000000_000252);
    @(negedge clk);
    check("lit_load", 64'(bus0.regUBASR), 64'(36'o000000_440252));
    tick();

    // INI with extra data that must be ignored
    wr(36'o000000_400377);
    @(negedge clk);
    check("lit_ini_reg", 64'(bus0.regUBASR), 64'(36'o000000_000100));
    cnt = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (init0) cnt++;
      else break;
    end
    check("lit_ini_len", 64'(cnt), 64'(INI));

    // Retrigger at cycle 30 -> high for 90 cycles in total
    tick();
    wr(36'o000000_000100);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (statWRITE) begin
        statWRITE = 1'b0;
        busDATAI  = '0;
      end
      if (init0) cnt++;
      else break;
      if (cnt == 30) begin
        busDATAI  = 36'o000000_000100;
        statWRITE = 1'b1;
      end
    end
    check("lit_ini_retrig", 64'(cnt), 64'(90));
    tick();

    // Interrupt routing: PIH=5, PIL=2
    wr(36'o000000_000052);
    devINTR[0][4] = 1'b1;
    tick();
    @(negedge clk);
    check("lit_intr_lo", 64'(intr0), 64'(7'b0100000));
    tick();
    devINTR[3][7] = 1'b1;
    tick();
    @(negedge clk);
    check("lit_intr_both", 64'(intr0), 64'(7'b0100100));
    tick();
    devINTR = '0;
    tick();
    @(negedge clk);
    check("lit_intr_drop", 64'(intr0), 64'(7'd0));
    tick();

    // PIH == PIL == 3 share a line
    wr(36'o000000_000033);
    devINTR[1][5] = 1'b1;
    tick();
    @(negedge clk);
    check("lit_intr_shared", 64'(intr0), 64'(7'b0010000));
    tick();
    devINTR = '0;
    tick();

    // Error interrupt on PIH=3 (only the ERR_INTR=1 instance)
    wr(36'o000000_000030);
    setTMO = 1'b1; tick(); setTMO = 1'b0;
    tick();
    @(negedge clk);
    check("lit_err_on", 64'(intr1), 64'(7'b0010000));
    check("lit_err_off", 64'(intr0), 64'(7'd0));
    tick();
    wr(36'o000000_400030);
    tick();
    @(negedge clk);
    check("lit_err_clr", 64'(intr1), 64'(7'd0));
    tick();

    // Reset in the middle of INI (counter at 10)
    wr(36'o000000_000100);
    setNXD = 1'b1; tick(); setNXD = 1'b0;
    repeat (49) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("lit_rst_init", 64'(init0), 64'(0));
    check("lit_rst_reg", 64'(bus0.regUBASR), 64'(36'o0));
    tick();
    rst = 1'b0;
    repeat (4) tick();

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uba_stat_ctl.md
Name: uba_stat_ctl

Overview:
Parametrised successor to the IO Bridge status register. It supports N attached devices and implements INI as a true timed one-shot that drives a bridge reset strobe. It also generates registered PI-level interrupt requests to the CPU from the PIH/PIL assignments, with an optional error interrupt. It sits in the UBA between the backplane bus decode and the per-device interface logic.

Parameters:
NUM_DEV, 4, number of attached IO devices (1..8)
INI_CYCLES, 60, clock cycles INI stays asserted (1 us at 60 MHz); must be >= 1
ERR_INTR, 0, 1 = a set TMO/NXD also raises an interrupt on the PIH level

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
busDATAI  input  [0:35]  backplane bus write data
statWRITE  input  1  one-cycle write strobe to the status register
setTMO  input  1  adapter timeout event
setNXD  input  1  non-existent device event; also sets TMO
devACLO  input  [NUM_DEV-1:0]  per-device power-fail
devINTR  input  [NUM_DEV-1:0][7:4]  per-device BR7..BR4 requests
regUBASR  output  [0:35]  status register read value
ubaINIT  output  1  bridge device reset, high while INI runs
ubaINTR  output  [1:7]  PI request lines to CPU, bit n = PI level n

Behaviour:
- Field layout (bits 18..35): TMO 18, BMD 19 = 0, BPE 20 = 0, NXD 21, 22-23 = 0, HI 24, LO 25, PWR 26, 27 = 0, DXF 28, INI 29, PIH 30:32, PIL 33:35. Bits 0..17 read 0.
- Reset: all state 0, so regUBASR = 0 apart from the live HI/LO/PWR bits. ubaINIT = 0, ubaINTR = 0, INI counter = 0.
- HI = OR of BR7|BR6 over all devices; LO = OR of BR5|BR4; PWR = OR of devACLO. All three are combinational and live.
- TMO and NXD are sticky and write-1-to-clear.
  - A set event in the same cycle as a clearing write wins: the bit stays/becomes 1.
  - setNXD sets both NXD and TMO.
- DXF, PIH and PIL are loaded from busDATAI on statWRITE.
- Write with bit 29 (INI) = 1:
  - Clears TMO, NXD, DXF, PIH and PIL; any other data in the same write is ignored.
  - A simultaneous set event still wins for TMO/NXD.
  - Loads the counter with INI_CYCLES.
- INI state:
  - INI (bit 29) and ubaINIT = (counter != 0). They rise the cycle after the write and stay high exactly INI_CYCLES cycles.
  - The counter decrements each cycle while non-zero and never wraps below 0.
  - A new INI write while counting reloads the counter to INI_CYCLES (retrigger).
- Interrupt output, registered with 1-cycle latency from its inputs:
  - ubaINTR[PIH] = 1 if HI, or if ERR_INTR and (TMO|NXD).
  - ubaINTR[PIL] = 1 if LO.
  - PIH = 0 or PIL = 0 disables that channel.
  - If PIH == PIL, the two requests OR onto the same line.
  - ubaINTR is forced to 0 while ubaINIT = 1.
- rst mid-INI: the counter clears immediately and ubaINIT drops the next cycle.
- Devices with index >= NUM_DEV do not exist; no tie-off is needed.

Decomposition:
- Shared package uba_pkg:
  - bit-position constants for TMO, NXD, HI, LO, PWR, DXF, INI, PIH, PIL;
  - field-extract functions for busDATAI;
  - typedef pia_t = logic [0:2].
- One sub-module, uba_oneshot (parameter CYCLES; ports trig in, busy out), holds the INI counter.
- Interrupt fan-in and the register build stay in the top module.

Test Plan:
- Reset, then read → regUBASR = 0. Set devINTR[2][6] = 1 → HI = 1 and regUBASR = 36'o000000_004000 (bit 24).
- Pulse setNXD → TMO = NXD = 1. Write busDATAI = 36'o000000_400000 (TMO only) → TMO = 0, NXD stays 1. Write 36'o000000_400000 in the same cycle as setTMO → TMO stays 1.
- Write INI with INI_CYCLES = 60 → ubaINIT high for exactly 60 cycles and PIH/PIL/DXF = 0. Re-write INI at cycle 30 → ubaINIT high through cycle 90.
- Write PIH = 5, PIL = 2, then assert devINTR[0][4] → ubaINTR = 7'b0100000 (PI 2) one cycle later. Add devINTR[3][7] → ubaINTR[5] also set. Drop both → ubaINTR = 0.
- ERR_INTR = 1, PIH = 3, pulse setTMO → ubaINTR[3] = 1 until TMO is cleared by a write-1.
- Assert rst at counter = 10 → ubaINIT = 0 next cycle and all fields = 0.
